// File: rtl/led_frame_pattern_gen.sv
// -----------------------------------------------------------------------------
// led_frame_pattern_gen
//
// Streams rows for a HUB75-style half-split LED panel. Each output word holds
// one half-row of the top half and the matching half-row of the bottom half
// (address A and A+HALF). The generator renders a selectable test pattern,
// accepts the row with a valid/ready handshake, and only changes pattern,
// effect position or PWM phase at frame boundaries so that a frame is always
// internally consistent.
//
// Ports
//   clk_in          : single clock, all logic on the rising edge
//   reset_in        : synchronous active-high reset
//   mode_in         : requested pattern (0 off, 1 solid, 2 hscan, 3 vscan,
//                     4 pulse, 5 checker, 6-7 off); sampled at frame start
//   colour_in       : {red,green,blue} mask for lit pixels, sampled per row load
//   row_out         : {top_r,top_g,top_b,bot_r,bot_g,bot_b}, NUM_COLS each,
//                     bit i of each plane = column i
//   row_valid_out   : row_out / row_address_out hold a row
//   row_ready_in    : consumer accepts the row when high together with valid
//   row_address_out : half-row index of row_out
//   frame_done_out  : one-cycle pulse when row 0 of a new frame is loaded
//                     after a completed frame
//   mode_active_out : pattern currently being rendered
// -----------------------------------------------------------------------------
module led_frame_pattern_gen #(
  parameter int NUM_COLS     = 64,
  parameter int NUM_ROWS     = 32,
  parameter int EFFECT_TICKS = 1_000_000,
  parameter int FADE_W       = 8,
  localparam int HALF        = NUM_ROWS / 2,
  localparam int ADDR_W      = $clog2(NUM_ROWS / 2)
) (
  input  logic                  clk_in,
  input  logic                  reset_in,
  input  logic [2:0]            mode_in,
  input  logic [2:0]            colour_in,
  output logic [6*NUM_COLS-1:0] row_out,
  output logic                  row_valid_out,
  input  logic                  row_ready_in,
  output logic [ADDR_W-1:0]     row_address_out,
  output logic                  frame_done_out,
  output logic [2:0]            mode_active_out
);

  localparam int HPOS_W = $clog2(NUM_COLS);
  localparam int VPOS_W = $clog2(NUM_ROWS);
  localparam int TMR_W  = (EFFECT_TICKS > 1) ? $clog2(EFFECT_TICKS) : 1;

  localparam logic [2:0] MODE_OFF     = 3'd0;
  localparam logic [2:0] MODE_SOLID   = 3'd1;
  localparam logic [2:0] MODE_HSCAN   = 3'd2;
  localparam logic [2:0] MODE_VSCAN   = 3'd3;
  localparam logic [2:0] MODE_PULSE   = 3'd4;
  localparam logic [2:0] MODE_CHECKER = 3'd5;

  // ST_LOAD: no row held yet (after reset); ST_RUN: a row is being offered.
  typedef enum logic [0:0] {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t state_r;
  state_t state_next_s;

  // Handshake / sequencing decisions
  logic accept_s;
  logic last_row_s;
  logic frame_start_s;
  logic load_s;
  logic frame_done_next_s;

  // Output registers
  logic [6*NUM_COLS-1:0] row_r;
  logic                  row_valid_r;
  logic [ADDR_W-1:0]     addr_r;
  logic                  frame_done_r;
  logic [2:0]            mode_active_r;

  // Frame-level state
  logic [FADE_W-1:0] pwm_r;
  logic [HPOS_W-1:0] snap_hpos_r;
  logic [VPOS_W-1:0] snap_vpos_r;
  logic [FADE_W-1:0] snap_fade_r;
  logic              snap_phase_r;

  // Live effect state
  logic [TMR_W-1:0]  timer_r;
  logic [HPOS_W-1:0] hpos_r;
  logic              hpos_up_r;
  logic [VPOS_W-1:0] vpos_r;
  logic              vpos_up_r;
  logic [FADE_W-1:0] fade_r;
  logic              fade_up_r;
  logic              phase_r;

  // Next-state values
  logic [2:0]            mode_req_s;
  logic                  mode_change_s;
  logic                  step_s;
  logic [TMR_W-1:0]      timer_next_s;
  logic                  hpos_turn_s;
  logic                  vpos_turn_s;
  logic                  fade_turn_s;
  logic [HPOS_W-1:0]     hpos_next_s;
  logic                  hpos_up_next_s;
  logic [VPOS_W-1:0]     vpos_next_s;
  logic                  vpos_up_next_s;
  logic [FADE_W-1:0]     fade_next_s;
  logic                  fade_up_next_s;
  logic                  phase_next_s;
  logic [2:0]            mode_next_s;
  logic [ADDR_W-1:0]     addr_next_s;
  logic [FADE_W-1:0]     pwm_next_s;
  logic [HPOS_W-1:0]     snap_hpos_next_s;
  logic [VPOS_W-1:0]     snap_vpos_next_s;
  logic [FADE_W-1:0]     snap_fade_next_s;
  logic                  snap_phase_next_s;
  logic [5:0]            px_s;
  logic [6*NUM_COLS-1:0] render_s;
  logic [6*NUM_COLS-1:0] row_next_s;

  // Pixel colours of one column for both halves: {top_rgb, bot_rgb}.
  // The bottom half row is addr+HALF with HALF a power of two, so its
  // physical row index is {1, addr} and it shares the parity of addr.
  function automatic logic [5:0] col_pixels(
    input logic [2:0]        mode,
    input logic [HPOS_W-1:0] col,
    input logic [ADDR_W-1:0] addr,
    input logic [HPOS_W-1:0] hpos,
    input logic [VPOS_W-1:0] vpos,
    input logic [FADE_W-1:0] fade,
    input logic [FADE_W-1:0] pwm,
    input logic              phase,
    input logic [2:0]        colour
  );
    logic top_lit;
    logic bot_lit;
    top_lit = 1'b0;
    bot_lit = 1'b0;
    case (mode)
      MODE_SOLID: begin
        top_lit = 1'b1;
        bot_lit = 1'b1;
      end
      MODE_HSCAN: begin
        top_lit = (col == hpos);
        bot_lit = (col == hpos);
      end
      MODE_VSCAN: begin
        top_lit = (vpos == {1'b0, addr});
        bot_lit = (vpos == {1'b1, addr});
      end
      MODE_PULSE: begin
        top_lit = (pwm < fade);
        bot_lit = (pwm < fade);
      end
      MODE_CHECKER: begin
        top_lit = col[0] ^ addr[0] ^ phase;
        bot_lit = col[0] ^ addr[0] ^ phase;
      end
      default: begin
        top_lit = 1'b0;
        bot_lit = 1'b0;
      end
    endcase
    return {({3{top_lit}} & colour), ({3{bot_lit}} & colour)};
  endfunction

  // FSM state register.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_r <= ST_LOAD;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next state and handshake decisions.
  always_comb begin
    state_next_s      = state_r;
    accept_s          = 1'b0;
    last_row_s        = (addr_r == ADDR_W'(HALF - 1));
    frame_start_s     = 1'b0;
    load_s            = 1'b0;
    frame_done_next_s = 1'b0;
    case (state_r)
      ST_LOAD: begin
        // Initial load after reset: a frame start that is not a frame end.
        frame_start_s = 1'b1;
        load_s        = 1'b1;
        state_next_s  = ST_RUN;
      end
      ST_RUN: begin
        accept_s          = row_ready_in;
        load_s            = row_ready_in;
        frame_start_s     = row_ready_in & last_row_s;
        frame_done_next_s = row_ready_in & last_row_s;
        state_next_s      = ST_RUN;
      end
      default: begin
        state_next_s = ST_LOAD;
      end
    endcase
  end

  // Effect timer, bouncing registers and frame-start snapshot.
  always_comb begin
    if (mode_in > MODE_CHECKER) begin
      mode_req_s = MODE_OFF;
    end else begin
      mode_req_s = mode_in;
    end
    mode_change_s = frame_start_s & (mode_req_s != mode_active_r);

    step_s = (timer_r == TMR_W'(EFFECT_TICKS - 1));
    if (step_s) begin
      timer_next_s = '0;
    end else begin
      timer_next_s = timer_r + TMR_W'(1);
    end

    // Ping-pong: flip direction at the end being approached, then move one
    // step in the (possibly new) direction, so ends are never repeated.
    hpos_turn_s = hpos_up_r ? (hpos_r == HPOS_W'(NUM_COLS - 1)) : (hpos_r == '0);
    vpos_turn_s = vpos_up_r ? (vpos_r == VPOS_W'(NUM_ROWS - 1)) : (vpos_r == '0);
    fade_turn_s = fade_up_r ? (fade_r == {FADE_W{1'b1}}) : (fade_r == '0);

    if (mode_change_s) begin
      hpos_next_s    = '0;
      hpos_up_next_s = 1'b1;
      vpos_next_s    = '0;
      vpos_up_next_s = 1'b1;
      fade_next_s    = '0;
      fade_up_next_s = 1'b1;
      phase_next_s   = 1'b0;
    end else if (step_s) begin
      hpos_up_next_s = hpos_up_r ^ hpos_turn_s;
      vpos_up_next_s = vpos_up_r ^ vpos_turn_s;
      fade_up_next_s = fade_up_r ^ fade_turn_s;
      hpos_next_s    = hpos_up_next_s ? (hpos_r + HPOS_W'(1)) : (hpos_r - HPOS_W'(1));
      vpos_next_s    = vpos_up_next_s ? (vpos_r + VPOS_W'(1)) : (vpos_r - VPOS_W'(1));
      fade_next_s    = fade_up_next_s ? (fade_r + FADE_W'(1)) : (fade_r - FADE_W'(1));
      phase_next_s   = ~phase_r;
    end else begin
      hpos_next_s    = hpos_r;
      hpos_up_next_s = hpos_up_r;
      vpos_next_s    = vpos_r;
      vpos_up_next_s = vpos_up_r;
      fade_next_s    = fade_r;
      fade_up_next_s = fade_up_r;
      phase_next_s   = phase_r;
    end

    // Snapshot takes the pre-step live values; a mode switch renders its
    // first frame from zero.
    if (mode_change_s) begin
      snap_hpos_next_s  = '0;
      snap_vpos_next_s  = '0;
      snap_fade_next_s  = '0;
      snap_phase_next_s = 1'b0;
    end else if (frame_start_s) begin
      snap_hpos_next_s  = hpos_r;
      snap_vpos_next_s  = vpos_r;
      snap_fade_next_s  = fade_r;
      snap_phase_next_s = phase_r;
    end else begin
      snap_hpos_next_s  = snap_hpos_r;
      snap_vpos_next_s  = snap_vpos_r;
      snap_fade_next_s  = snap_fade_r;
      snap_phase_next_s = snap_phase_r;
    end
  end

  // Row sequencing and rendering of the row about to be loaded.
  always_comb begin
    if (frame_start_s) begin
      mode_next_s = mode_req_s;
      addr_next_s = '0;
      pwm_next_s  = pwm_r + FADE_W'(1);
    end else if (accept_s) begin
      mode_next_s = mode_active_r;
      addr_next_s = addr_r + ADDR_W'(1);
      pwm_next_s  = pwm_r;
    end else begin
      mode_next_s = mode_active_r;
      addr_next_s = addr_r;
      pwm_next_s  = pwm_r;
    end

    render_s = '0;
    px_s     = '0;
    for (int c = 0; c < NUM_COLS; c++) begin
      px_s = col_pixels(mode_next_s, HPOS_W'(c), addr_next_s, snap_hpos_next_s,
                        snap_vpos_next_s, snap_fade_next_s, pwm_next_s,
                        snap_phase_next_s, colour_in);
      for (int p = 0; p < 6; p++) begin
        render_s[p*NUM_COLS + c] = px_s[p];
      end
    end

    if (load_s) begin
      row_next_s = render_s;
    end else begin
      row_next_s = row_r;
    end
  end

  // Datapath registers; reset dominates everything.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      row_r         <= '0;
      row_valid_r   <= 1'b0;
      addr_r        <= '0;
      frame_done_r  <= 1'b0;
      mode_active_r <= MODE_OFF;
      pwm_r         <= '0;
      snap_hpos_r   <= '0;
      snap_vpos_r   <= '0;
      snap_fade_r   <= '0;
      snap_phase_r  <= 1'b0;
      timer_r       <= '0;
      hpos_r        <= '0;
      hpos_up_r     <= 1'b1;
      vpos_r        <= '0;
      vpos_up_r     <= 1'b1;
      fade_r        <= '0;
      fade_up_r     <= 1'b1;
      phase_r       <= 1'b0;
    end else begin
      row_r         <= row_next_s;
      row_valid_r   <= 1'b1;
      addr_r        <= addr_next_s;
      frame_done_r  <= frame_done_next_s;
      mode_active_r <= mode_next_s;
      pwm_r         <= pwm_next_s;
      snap_hpos_r   <= snap_hpos_next_s;
      snap_vpos_r   <= snap_vpos_next_s;
      snap_fade_r   <= snap_fade_next_s;
      snap_phase_r  <= snap_phase_next_s;
      timer_r       <= timer_next_s;
      hpos_r        <= hpos_next_s;
      hpos_up_r     <= hpos_up_next_s;
      vpos_r        <= vpos_next_s;
      vpos_up_r     <= vpos_up_next_s;
      fade_r        <= fade_next_s;
      fade_up_r     <= fade_up_next_s;
      phase_r       <= phase_next_s;
    end
  end

  assign row_out         = row_r;
  assign row_valid_out   = row_valid_r;
  assign row_address_out = addr_r;
  assign frame_done_out  = frame_done_r;
  assign mode_active_out = mode_active_r;

endmodule

// File: tb/tb_led_frame_pattern_gen.sv
// -----------------------------------------------------------------------------
// tb_led_frame_pattern_gen
//
// Scoreboard bench. A reference model evaluated at every rising edge derives
// the expected output state from the pattern rules (effect values in closed
// form from the number of effect steps) and pushes it into a queue; a monitor
// on the falling edge pops each entry and compares it with the DUT outputs.
// -----------------------------------------------------------------------------
module tb_led_frame_pattern_gen;

  localparam int NC     = 8;
  localparam int NR     = 32;
  localparam int TICKS  = 4;
  localparam int FW     = 2;
  localparam int HALF   = NR / 2;
  localparam int AW     = $clog2(HALF);
  localparam int RW     = 6 * NC;
  localparam int FMAX   = (1 << FW) - 1;

  logic          clk_in       = 1'b0;
  logic          reset_in     = 1'b1;
  logic [2:0]    mode_in      = 3'd0;
  logic [2:0]    colour_in    = 3'd0;
  logic          row_ready_in = 1'b0;
  logic [RW-1:0] row_out;
  logic          row_valid_out;
  logic [AW-1:0] row_address_out;
  logic          frame_done_out;
  logic [2:0]    mode_active_out;

  led_frame_pattern_gen #(
    .NUM_COLS    (NC),
    .NUM_ROWS    (NR),
    .EFFECT_TICKS(TICKS),
    .FADE_W      (FW)
  ) dut (
    .clk_in         (clk_in),
    .reset_in       (reset_in),
    .mode_in        (mode_in),
    .colour_in      (colour_in),
    .row_out        (row_out),
    .row_valid_out  (row_valid_out),
    .row_ready_in   (row_ready_in),
    .row_address_out(row_address_out),
    .frame_done_out (frame_done_out),
    .mode_active_out(mode_active_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic          valid;
    logic [AW-1:0] addr;
    logic [RW-1:0] row;
    logic          fd;
    logic [2:0]    mode;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   started = 1'b0;

  // Reference model state
  bit            m_valid;
  int            m_addr, m_mode, m_pwm, m_tcount, m_steps;
  int            s_h, s_v, s_f, s_p;
  logic [RW-1:0] m_row;
  bit            m_fd;

  // Position after k steps of a 0..mx ping-pong starting at 0 going up.
  function automatic int bounce(int k, int mx);
    int p;
    p = k % (2 * mx);
    return (p <= mx) ? p : (2 * mx - p);
  endfunction

  function automatic logic [RW-1:0] render(int addr, int mode, int h, int v,
                                           int f, int ph, int pwm, logic [2:0] col);
    logic [RW-1:0] r;
    int            prow;
    bit            lit;
    r = '0;
    for (int half = 0; half < 2; half++) begin
      prow = addr + half * HALF;
      for (int c = 0; c < NC; c++) begin
        case (mode)
          1:       lit = 1'b1;
          2:       lit = (c == h);
          3:       lit = (prow == v);
          4:       lit = (pwm < f);
          5:       lit = (((c + prow + ph) % 2) == 1);
          default: lit = 1'b0;
        endcase
        for (int k = 0; k < 3; k++) begin
          if (lit && col[2-k]) r[(5 - (half * 3 + k)) * NC + c] = 1'b1;
        end
      end
    end
    return r;
  endfunction

  task automatic model_edge();
    exp_t e;
    bit   accept, fstart, step, change;
    int   req;
    if (reset_in) begin
      m_valid = 0; m_addr = 0; m_mode = 0; m_pwm = 0; m_tcount = 0; m_steps = 0;
      s_h = 0; s_v = 0; s_f = 0; s_p = 0; m_row = '0; m_fd = 0;
    end else begin
      accept = m_valid && row_ready_in;
      fstart = !m_valid || (accept && m_addr == HALF - 1);
      m_fd   = m_valid && fstart;
      step   = (m_tcount % TICKS) == TICKS - 1;
      req    = (mode_in > 3'd5) ? 0 : int'(mode_in);
      change = fstart && (req != m_mode);
      if (fstart) begin
        if (change) begin
          s_h = 0; s_v = 0; s_f = 0; s_p = 0;
        end else begin
          s_h = bounce(m_steps, NC - 1);
          s_v = bounce(m_steps, NR - 1);
          s_f = bounce(m_steps, FMAX);
          s_p = m_steps % 2;
        end
        m_mode = req;
        m_pwm  = (m_pwm + 1) % (FMAX + 1);
        m_addr = 0;
      end else if (accept) begin
        m_addr = m_addr + 1;
      end
      if (change) m_steps = 0;
      else if (step) m_steps = m_steps + 1;
      m_tcount = m_tcount + 1;
      if (fstart || accept)
        m_row = render(m_addr, m_mode, s_h, s_v, s_f, s_p, m_pwm, colour_in);
      m_valid = 1;
    end
    e.valid = m_valid;
    e.addr  = m_addr[AW-1:0];
    e.row   = m_row;
    e.fd    = m_fd;
    e.mode  = m_mode[2:0];
    sb.push_back(e);
    started = 1'b1;
  endtask

  initial begin
    forever begin
      @(posedge clk_in);
      model_edge();
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare every presented output state with the scoreboard.
  initial begin
    forever begin
      @(negedge clk_in);
      if (sb.size() == 0) begin
        if (started) begin
          n_tests++;
          n_fail++;
          $display("FAIL sb_empty: got no expected entry at %0t", $time);
        end
      end else begin
        mon_e = sb.pop_front();
        check("valid", 64'(row_valid_out), 64'(mon_e.valid));
        check("addr", 64'(row_address_out), 64'(mon_e.addr));
        check("row", 64'(row_out), 64'(mon_e.row));
        check("frame_done", 64'(frame_done_out), 64'(mon_e.fd));
        check("mode_active", 64'(mode_active_out), 64'(mon_e.mode));
      end
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic wait_addr(input int a);
    int k;
    k = 0;
    while (!(m_valid && m_addr == a) && k < 100) begin
      tick();
      k++;
    end
    n_tests++;
    if (!(m_valid && m_addr == a)) begin
      n_fail++;
      $display("FAIL wait_addr: got %0d expected %0d", m_addr, a);
    end
  endtask

  initial begin
    // Reset, then solid red with ready held high.
    repeat (3) tick();
    mode_in      = 3'd1;
    colour_in    = 3'b100;
    row_ready_in = 1'b1;
    reset_in     = 1'b0;
    repeat (40) tick();

    // Stall at address 5 for ten cycles.
    wait_addr(5);
    row_ready_in = 1'b0;
    repeat (10) tick();
    row_ready_in = 1'b1;
    repeat (5) tick();

    // Mode change mid-frame at address 7: solid -> vscan.
    wait_addr(7);
    mode_in = 3'd3;
    repeat (40) tick();

    // Hscan and pulse over many frames with varying colours.
    mode_in = 3'd2;
    for (int i = 0; i < 300; i++) begin
      tick();
      colour_in = 3'($urandom_range(1, 7));
    end
    mode_in = 3'd4;
    colour_in = 3'b111;
    repeat (400) tick();

    // Reset mid-frame at address 9, then a new mode is sampled.
    mode_in = 3'd5;
    repeat (20) tick();
    wait_addr(9);
    reset_in = 1'b1;
    mode_in  = 3'd2;
    tick();
    reset_in = 1'b0;
    repeat (40) tick();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      tick();
      row_ready_in = ($urandom_range(0, 3) != 0);
      colour_in    = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 59) == 0) mode_in = 3'($urandom_range(0, 7));
      reset_in     = ($urandom_range(0, 499) == 0);
    end
    reset_in = 1'b0;
    repeat (3) tick();
    @(negedge clk_in);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
